// File: rtl/aucohl_fifo_serializer.sv
// ---------------------------------------------------------------------------
// aucohl_fifo_serializer
//
// Read side of aucohl_fifo. Pops words from a first-word-fall-through FIFO
// and shifts each one out on a single line, framed UART-style: one start bit
// (low), DW data bits LSB-first, then STOP_BITS stop bits (high). Each bit
// lasts clk_div+1 enabled clk cycles.
//
// Ports
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   en          in   global enable; low freezes every piece of state
//   clk_div     in   [PW-1:0] bit period minus one, in clk cycles
//   fifo_empty  in   FIFO empty flag
//   fifo_rdata  in   [DW-1:0] FIFO head word, valid while fifo_empty is low
//   fifo_rd     out  FIFO pop strobe, one cycle per word (combinational)
//   tx          out  serial output, idle high (registered)
//   busy        out  frame in progress (registered)
//   done        out  one-cycle pulse after the last stop bit (registered)
// ---------------------------------------------------------------------------
module aucohl_fifo_serializer #(
    parameter int DW        = 8,
    parameter int PW        = 16,
    parameter int STOP_BITS = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [PW-1:0] clk_div,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_rdata,
    output logic          fifo_rd,
    output logic          tx,
    output logic          busy,
    output logic          done
);

    localparam int BW = $clog2(DW + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [BW-1:0] LAST_DATA = BW'(DW - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    logic [1:0]    state_q,   state_d;
    logic          tx_q,      tx_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;
    logic [DW-1:0] shift_q,   shift_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;

    logic bit_end;
    logic frame_end;
    logic pop;

    // A bit ends on the enabled cycle where the prescaler has run down to 0.
    // frame_end marks the final cycle of the final stop bit, which is the
    // only moment besides IDLE where the next word may be popped, so
    // back-to-back frames have no idle gap.
    always_comb begin
        bit_end   = en && (pre_cnt_q == '0);
        frame_end = (state_q == S_STOP) && bit_end && (bit_cnt_q == LAST_STOP);
        pop       = rst_n && en && !fifo_empty &&
                    ((state_q == S_IDLE) || frame_end);
    end

    assign fifo_rd = pop;

    // Next-state logic. tx is registered, so tx_d always carries the level
    // of the bit that starts in the next cycle. clk_div is only sampled when
    // a new bit starts, so changing it mid-bit does not disturb the current
    // bit. With en low nothing is updated at all, so a frame resumes exactly
    // where it stopped.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        pre_cnt_d = pre_cnt_q;

        if (en) begin
            if ((state_q != S_IDLE) && (pre_cnt_q != '0)) begin
                pre_cnt_d = pre_cnt_q - PW'(1);
            end

            case (state_q)
                S_START: begin
                    if (bit_end) begin
                        state_d   = S_DATA;
                        tx_d      = shift_q[0];
                        bit_cnt_d = '0;
                        pre_cnt_d = clk_div;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shift_d   = shift_q >> 1;
                        pre_cnt_d = clk_div;
                        if (bit_cnt_q == LAST_DATA) begin
                            state_d   = S_STOP;
                            tx_d      = 1'b1;
                            bit_cnt_d = '0;
                        end else begin
                            tx_d      = shift_q[1];
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        pre_cnt_d = clk_div;
                        if (bit_cnt_q == LAST_STOP) begin
                            state_d   = S_IDLE;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                            bit_cnt_d = '0;
                            pre_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase

            // A pop overrides the IDLE transition above, chaining straight
            // into the next start bit while busy stays high.
            if (pop) begin
                state_d   = S_START;
                tx_d      = 1'b0;
                busy_d    = 1'b1;
                shift_d   = fifo_rdata;
                bit_cnt_d = '0;
                pre_cnt_d = clk_div;
            end
        end
    end

    // Reset drops the line to idle immediately; a word popped before reset
    // is simply lost and no done pulse is produced for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            pre_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            pre_cnt_q <= pre_cnt_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_aucohl_fifo_serializer.sv
// ---------------------------------------------------------------------------
// tb_aucohl_fifo_serializer
//
// Directed bench for aucohl_fifo_serializer. dut_a uses one stop bit and is
// fed from a small FIFO model; dut_b uses two stop bits and has its own
// single-word feed. Expected line levels come from a framing model
// (start, data LSB-first, stop) computed from the word and divider.
// ---------------------------------------------------------------------------
module tb_aucohl_fifo_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b1;
    logic [15:0] clk_div = 16'd3;

    // FIFO model feeding dut_a
    logic [7:0]  fifo_mem [0:15];
    logic [3:0]  wr_ptr = 4'd0;
    logic [3:0]  rd_ptr = 4'd0;
    logic        fifo_empty_a;
    logic [7:0]  fifo_rdata_a;
    logic        fifo_rd_a, tx_a, busy_a, done_a;

    // single-word feed for dut_b
    logic [7:0]  rdata_b = 8'h00;
    logic [3:0]  wr_b = 4'd0;
    logic [3:0]  rd_b = 4'd0;
    logic        fifo_empty_b;
    logic        fifo_rd_b, tx_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;
    int pop_cnt = 0;
    int done_cnt = 0;

    assign fifo_empty_a = (wr_ptr == rd_ptr);
    assign fifo_rdata_a = fifo_mem[rd_ptr];
    assign fifo_empty_b = (wr_b == rd_b);

    aucohl_fifo_serializer #(.DW(8), .PW(16), .STOP_BITS(1)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clk_div    (clk_div),
        .fifo_empty (fifo_empty_a),
        .fifo_rdata (fifo_rdata_a),
        .fifo_rd    (fifo_rd_a),
        .tx         (tx_a),
        .busy       (busy_a),
        .done       (done_a)
    );

    aucohl_fifo_serializer #(.DW(8), .PW(16), .STOP_BITS(2)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clk_div    (clk_div),
        .fifo_empty (fifo_empty_b),
        .fifo_rdata (rdata_b),
        .fifo_rd    (fifo_rd_b),
        .tx         (tx_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    always #5 clk = ~clk;

    // FIFO read side and event counters
    always @(posedge clk) begin
        if (fifo_rd_a) begin
            rd_ptr  <= rd_ptr + 4'd1;
            pop_cnt <= pop_cnt + 1;
        end
        if (fifo_rd_b) begin
            rd_b <= rd_b + 4'd1;
        end
        if (done_a) begin
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] word);
        fifo_mem[wr_ptr] = word;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    // Line level expected in active cycle c (1-based) of a frame
    function automatic logic expBit(input logic [7:0] word, input int div, input int c);
        int n;
        n = (c - 1) / (div + 1);
        if (n == 0) return 1'b0;
        if (n <= 8) return word[n-1];
        return 1'b1;
    endfunction

    // Walks one frame cycle by cycle. sel picks the DUT; more says another
    // word is waiting so a pop is due on the final cycle; prev_done says the
    // previous frame ended just before this one; en is pulled low for
    // freeze_len cycles right after active cycle freeze_at.
    task automatic checkFrame(input int sel, input logic [7:0] word, input int div, input int nstop,
                              input bit more, input bit prev_done, input int freeze_at, input int freeze_len);
        int total;
        logic otx, obusy, odone, ord;
        total = (1 + 8 + nstop) * (div + 1);
        for (int c = 1; c <= total; c++) begin
            tick();
            otx   = sel ? tx_b : tx_a;
            obusy = sel ? busy_b : busy_a;
            odone = sel ? done_b : done_a;
            ord   = sel ? fifo_rd_b : fifo_rd_a;
            checkOutput($sformatf("w%02h c%0d tx", word, c), 32'(otx), 32'(expBit(word, div, c)));
            checkOutput($sformatf("w%02h c%0d busy", word, c), 32'(obusy), 32'd1);
            checkOutput($sformatf("w%02h c%0d done", word, c), 32'(odone), 32'((c == 1) && prev_done));
            checkOutput($sformatf("w%02h c%0d fifo_rd", word, c), 32'(ord), 32'((c == total) && more));
            if (c == freeze_at) begin
                en = 1'b0;
                for (int f = 1; f <= freeze_len; f++) begin
                    tick();
                    otx   = sel ? tx_b : tx_a;
                    obusy = sel ? busy_b : busy_a;
                    odone = sel ? done_b : done_a;
                    ord   = sel ? fifo_rd_b : fifo_rd_a;
                    checkOutput($sformatf("w%02h frz%0d tx", word, f), 32'(otx), 32'(expBit(word, div, c)));
                    checkOutput($sformatf("w%02h frz%0d busy", word, f), 32'(obusy), 32'd1);
                    checkOutput($sformatf("w%02h frz%0d done", word, f), 32'(odone), 32'd0);
                    checkOutput($sformatf("w%02h frz%0d fifo_rd", word, f), 32'(ord), 32'd0);
                end
                en = 1'b1;
            end
        end
        if (!more) begin
            tick();
            checkOutput($sformatf("w%02h end done", word), 32'(sel ? done_b : done_a), 32'd1);
            checkOutput($sformatf("w%02h end busy", word), 32'(sel ? busy_b : busy_a), 32'd0);
            checkOutput($sformatf("w%02h end tx", word), 32'(sel ? tx_b : tx_a), 32'd1);
            tick();
            checkOutput($sformatf("w%02h post done", word), 32'(sel ? done_b : done_a), 32'd0);
            checkOutput($sformatf("w%02h post fifo_rd", word), 32'(sel ? fifo_rd_b : fifo_rd_a), 32'd0);
        end
    endtask

    initial begin
        // reset held with FIFO non-empty and en high
        #2 rst_n = 1'b0;
        en      = 1'b1;
        clk_div = 16'd3;
        applyStimulus(8'hA5);
        repeat (3) tick();
        checkOutput("rst tx", 32'(tx_a), 32'd1);
        checkOutput("rst busy", 32'(busy_a), 32'd0);
        checkOutput("rst done", 32'(done_a), 32'd0);
        checkOutput("rst fifo_rd", 32'(fifo_rd_a), 32'd0);
        checkOutput("rst tx_b", 32'(tx_b), 32'd1);

        // single word 0xA5, 4 cycles per bit
        rst_n = 1'b1;
        #1;
        checkOutput("a5 pop", 32'(fifo_rd_a), 32'd1);
        checkFrame(0, 8'hA5, 3, 1, 1'b0, 1'b0, -1, 0);

        // three words back to back, 1 cycle per bit
        clk_div = 16'd0;
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        applyStimulus(8'h3C);
        #1;
        checkOutput("b2b pop", 32'(fifo_rd_a), 32'd1);
        checkFrame(0, 8'h00, 0, 1, 1'b1, 1'b0, -1, 0);
        checkFrame(0, 8'hFF, 0, 1, 1'b1, 1'b1, -1, 0);
        checkFrame(0, 8'h3C, 0, 1, 1'b0, 1'b1, -1, 0);

        // en low for 5 cycles inside data bit 2
        clk_div = 16'd3;
        applyStimulus(8'h5A);
        #1;
        checkOutput("5a pop", 32'(fifo_rd_a), 32'd1);
        checkFrame(0, 8'h5A, 3, 1, 1'b0, 1'b0, 14, 5);

        // reset during data bit 4, then 0x81 goes out cleanly
        applyStimulus(8'h0F);
        applyStimulus(8'h81);
        #1;
        checkOutput("0f pop", 32'(fifo_rd_a), 32'd1);
        for (int c = 1; c <= 22; c++) begin
            tick();
            checkOutput($sformatf("w0f c%0d tx", c), 32'(tx_a), 32'(expBit(8'h0F, 3, c)));
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midrst tx", 32'(tx_a), 32'd1);
        checkOutput("midrst busy", 32'(busy_a), 32'd0);
        checkOutput("midrst fifo_rd", 32'(fifo_rd_a), 32'd0);
        tick();
        checkOutput("midrst done", 32'(done_a), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("81 pop", 32'(fifo_rd_a), 32'd1);
        checkFrame(0, 8'h81, 3, 1, 1'b0, 1'b0, -1, 0);

        // two stop bits, 2 cycles per bit
        clk_div = 16'd1;
        rdata_b = 8'hC3;
        wr_b    = wr_b + 4'd1;
        #1;
        checkOutput("c3 pop", 32'(fifo_rd_b), 32'd1);
        checkFrame(1, 8'hC3, 1, 2, 1'b0, 1'b0, -1, 0);

        checkOutput("pop count", 32'(pop_cnt), 32'd7);
        checkOutput("done count", 32'(done_cnt), 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
